// File: rtl/dac_pkg.sv
// dac_pkg
//   Shared types and helpers for the PMOD DAC waveform datapath.
//   - DAC_WIDTH  : width of the DAC sample byte
//   - dac_mode_t : waveform mode, encoded as reported on o_Mode
//   - dac_wave() : maps (mode, phase) to the DAC byte
package dac_pkg;

    localparam int DAC_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_SAW      = 2'd0,
        MODE_SQUARE   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_HOLD     = 2'd3
    } dac_mode_t;

    function automatic logic [DAC_WIDTH-1:0] dac_wave(
        input dac_mode_t                mode,
        input logic [DAC_WIDTH-1:0]     phase
    );
        logic [DAC_WIDTH-1:0] folded;
        folded = {phase[DAC_WIDTH-2:0], 1'b0};
        case (mode)
            MODE_SAW:      return phase;
            MODE_SQUARE:   return {DAC_WIDTH{phase[DAC_WIDTH-1]}};
            // Upper half of the phase runs the doubled ramp back down.
            MODE_TRIANGLE: return phase[DAC_WIDTH-1] ? ~folded : folded;
            // HOLD never issues a sample; the value is irrelevant.
            default:       return phase;
        endcase
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// dac_tick_gen
//   Sample-rate divider. Counts 0..SAMPLE_DIV-1 while enabled and flags
//   the last count of each period. Disabling clears the count, so a
//   re-enable always starts a full period.
//   Ports:
//     i_Clk     system clock
//     i_Rst_L   asynchronous active-low reset
//     i_Enable  level, 1 = divider runs
//     o_Tick    high during the cycle whose count is SAMPLE_DIV-1
module dac_tick_gen #(
    parameter int SAMPLE_DIV = 25
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (!i_Enable || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Decoded straight from the count register; gated by enable so a
    // disable in the terminal cycle drops the tick.
    assign o_Tick = i_Enable && (count == LAST_COUNT);

endmodule

// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer
//   Schedules DAC samples and generates the sample byte from a phase
//   accumulator in one of four waveform modes, stepped by a push-button.
//   Ports:
//     i_Clk           system clock (25 MHz)
//     i_Rst_L         asynchronous active-low reset
//     i_Enable        level, 1 = sample scheduling runs
//     i_Mode_Next     debounced button level; rising edge advances the mode
//     i_Step          phase increment, sampled on the tick cycle
//     o_Byte          registered DAC sample
//     o_Sample_Valid  one-cycle pulse with each new o_Byte
//     o_Mode          current waveform mode
//
//   Mode FSM:
//     state          | meaning
//     MODE_SAW       | byte = phase
//     MODE_SQUARE    | byte = phase msb replicated
//     MODE_TRIANGLE  | byte = folded, doubled phase
//     MODE_HOLD      | phase and byte frozen, no sample pulses
module dac_wave_sequencer
    import dac_pkg::*;
#(
    parameter int SAMPLE_DIV = 25
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Enable,
    input  logic                 i_Mode_Next,
    input  logic [DAC_WIDTH-1:0] i_Step,
    output logic [DAC_WIDTH-1:0] o_Byte,
    output logic                 o_Sample_Valid,
    output logic [1:0]           o_Mode
);

    dac_mode_t            mode_q;
    dac_mode_t            mode_d;
    logic                 mode_next_q;
    logic                 mode_edge;
    logic                 tick;
    logic                 issue;
    logic [DAC_WIDTH-1:0] phase;

    dac_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (i_Enable),
        .o_Tick   (tick)
    );

    assign mode_edge = i_Mode_Next && !mode_next_q;

    // A mode edge in the tick cycle wins: that period's sample is dropped
    // and the next one uses the new mode from phase 0.
    assign issue = tick && !mode_edge && (mode_q != MODE_HOLD);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q      <= MODE_SAW;
            mode_next_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            mode_next_q <= i_Mode_Next;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_edge) begin
            case (mode_q)
                MODE_SAW:      mode_d = MODE_SQUARE;
                MODE_SQUARE:   mode_d = MODE_TRIANGLE;
                MODE_TRIANGLE: mode_d = MODE_HOLD;
                MODE_HOLD:     mode_d = MODE_SAW;
                default:       mode_d = MODE_SAW;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            phase          <= '0;
            o_Byte         <= '0;
            o_Sample_Valid <= 1'b0;
        end else begin
            o_Sample_Valid <= issue;
            if (mode_edge) begin
                phase <= '0;
            end else if (issue) begin
                phase <= phase + i_Step;
            end
            // Sample uses the pre-increment phase.
            if (issue) begin
                o_Byte <= dac_wave(mode_q, phase);
            end
        end
    end

    assign o_Mode = mode_q;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
module tb_dac_wave_sequencer;

    localparam int DIV = 4;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_Enable;
    logic       i_Mode_Next;
    logic [7:0] i_Step;
    logic [7:0] o_Byte;
    logic       o_Sample_Valid;
    logic [1:0] o_Mode;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_cyc = 0;

    typedef struct {
        logic [7:0] step;
        logic [1:0] exp_mode;
        int         n;
        logic [7:0] bytes [10];
    } vec_t;

    vec_t vecs [2];

    dac_wave_sequencer #(
        .SAMPLE_DIV (DIV)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Enable       (i_Enable),
        .i_Mode_Next    (i_Mode_Next),
        .i_Step         (i_Step),
        .o_Byte         (o_Byte),
        .o_Sample_Valid (o_Sample_Valid),
        .o_Mode         (o_Mode)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_pulse(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(negedge i_Clk);
            n++;
            if (o_Sample_Valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no sample pulse within 40 cycles (t=%0t)", name, $time);
        end
    endtask

    // Pulse a sample and check byte and spacing from the previous pulse.
    task automatic expect_pulse(input string name, input logic [7:0] exp_byte, input int exp_gap);
        bit ok;
        wait_pulse(name, ok);
        if (ok) begin
            check({name, "_byte"}, int'(o_Byte), int'(exp_byte));
            if (exp_gap > 0) check({name, "_gap"}, cyc - last_cyc, exp_gap);
            last_cyc = cyc;
        end
    endtask

    task automatic mode_edge();
        i_Mode_Next = 1'b1;
        @(negedge i_Clk);
        i_Mode_Next = 1'b0;
    endtask

    initial begin
        int bad;
        int en_cyc;

        vecs[0].step     = 8'd64;
        vecs[0].exp_mode = 2'd1;
        vecs[0].n        = 5;
        vecs[0].bytes    = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].step     = 8'd32;
        vecs[1].exp_mode = 2'd2;
        vecs[1].n        = 10;
        vecs[1].bytes    = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00, 8'h40};

        i_Rst_L     = 1'b0;
        i_Enable    = 1'b0;
        i_Mode_Next = 1'b0;
        i_Step      = 8'h00;
        repeat (3) @(negedge i_Clk);
        check("reset_byte", int'(o_Byte), 0);
        check("reset_valid", int'(o_Sample_Valid), 0);
        check("reset_mode", int'(o_Mode), 0);

        // Sawtooth with step 1 through a full wrap; first pulse DIV cycles after release.
        i_Step   = 8'd1;
        i_Enable = 1'b1;
        i_Rst_L  = 1'b1;
        last_cyc = cyc;
        for (int i = 0; i < 258; i++) begin
            expect_pulse("saw", 8'(i), DIV);
        end

        // Table: one mode edge right after a pulse, new step, then a byte sequence.
        for (int v = 0; v < 2; v++) begin
            i_Step = vecs[v].step;
            mode_edge();
            check("table_mode", int'(o_Mode), int'(vecs[v].exp_mode));
            for (int k = 0; k < vecs[v].n; k++) begin
                expect_pulse("table", vecs[v].bytes[k], DIV);
            end
        end

        // HOLD: byte frozen at last triangle value, no pulses.
        mode_edge();
        check("hold_mode", int'(o_Mode), 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_Clk);
            if (o_Sample_Valid || o_Byte != 8'h40) bad++;
        end
        check("hold_quiet", bad, 0);

        // Fourth edge wraps to SAW from phase 0.
        i_Step = 8'h30;
        mode_edge();
        check("wrap_mode", int'(o_Mode), 0);
        expect_pulse("wrap_first", 8'h00, 0);
        expect_pulse("wrap_saw", 8'h30, DIV);
        expect_pulse("wrap_saw", 8'h60, DIV);

        // Mode edge coincident with the tick cycle: sample suppressed.
        repeat (3) @(negedge i_Clk);
        i_Step = 8'h80;
        mode_edge();
        check("coinc_no_pulse", int'(o_Sample_Valid), 0);
        check("coinc_mode", int'(o_Mode), 1);
        expect_pulse("coinc_next", 8'h00, 2 * DIV);
        expect_pulse("coinc_after", 8'hFF, DIV);

        // Enable dropped at count 2 for 10 cycles; a mode edge is still taken.
        repeat (2) @(negedge i_Clk);
        i_Enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) i_Mode_Next = 1'b1;
            if (i == 5) i_Mode_Next = 1'b0;
            @(negedge i_Clk);
            if (o_Sample_Valid || o_Byte != 8'hFF) bad++;
        end
        check("disable_quiet", bad, 0);
        check("disable_mode", int'(o_Mode), 2);
        i_Enable = 1'b1;
        en_cyc   = cyc;
        last_cyc = cyc;
        expect_pulse("reenable", 8'h00, 0);
        check("reenable_gap", cyc - en_cyc, DIV);
        expect_pulse("reenable_next", 8'hFF, DIV);

        // Asynchronous reset in the middle of the valid cycle.
        #2 i_Rst_L = 1'b0;
        #1;
        check("async_rst_byte", int'(o_Byte), 0);
        check("async_rst_valid", int'(o_Sample_Valid), 0);
        check("async_rst_mode", int'(o_Mode), 0);

        @(negedge i_Clk);
        i_Rst_L  = 1'b1;
        last_cyc = cyc;
        expect_pulse("post_rst", 8'h00, DIV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
